// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial sequence generator: FSM encoding and
// default sizing of the pattern, repeat and gap fields.
package sequence_generator_pkg;

    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_REP_W   = 8;
    localparam int DEF_GAP_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_gen_shifter.sv
// Pattern store, working shift register and per-frame bit counter.
// The bit for each operation is offered combinationally so the top can register it.
module seq_gen_shifter #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               restart,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               first_bit,
    output logic               restart_bit,
    output logic               shift_bit,
    output logic               last
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] sh_q, sh_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [MAX_LEN-1:0] aligned;

    // Left-align so the first bit to send always sits in the MSB.
    always_comb begin
        aligned = pattern << (LEN_W'(MAX_LEN) - len);
    end

    assign first_bit   = aligned[MAX_LEN-1];
    assign restart_bit = pat_q[MAX_LEN-1];
    assign shift_bit   = sh_q[MAX_LEN-1];
    // cnt counts bits still to send after the one currently on the output.
    assign last        = (cnt_q == '0);

    always_comb begin
        pat_d = pat_q;
        sh_d  = sh_q;
        len_d = len_q;
        cnt_d = cnt_q;
        if (load) begin
            pat_d = aligned;
            len_d = len;
            sh_d  = aligned << 1;
            cnt_d = len - LEN_W'(1);
        end else if (restart) begin
            sh_d  = pat_q << 1;
            cnt_d = len_q - LEN_W'(1);
        end else if (shift) begin
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= '0;
            sh_q  <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            sh_q  <= sh_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern generator: sends a latched bit pattern MSB-first for a number
// of frames (0 = forever) with an optional idle gap between frames.
module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int REP_W   = DEF_REP_W,
    parameter int GAP_W   = DEF_GAP_W,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   repeats,
    input  logic [GAP_W-1:0]   gap,
    input  logic               abort,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [REP_W-1:0]   frames_q, frames_d;
    logic               cont_q, cont_d;
    logic [GAP_W-1:0]   gap_len_q, gap_len_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic sh_load, sh_restart, sh_shift;
    logic sh_first_bit, sh_restart_bit, sh_shift_bit, sh_last;
    logic len_ok, final_frame;

    seq_gen_shifter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (sh_load),
        .restart     (sh_restart),
        .shift       (sh_shift),
        .pattern     (pattern),
        .len         (len),
        .first_bit   (sh_first_bit),
        .restart_bit (sh_restart_bit),
        .shift_bit   (sh_shift_bit),
        .last        (sh_last)
    );

    always_comb begin
        state_d    = state_q;
        frames_d   = frames_q;
        cont_d     = cont_q;
        gap_len_d  = gap_len_q;
        gap_cnt_d  = gap_cnt_q;
        x_d        = 1'b0;
        x_valid_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        sh_load    = 1'b0;
        sh_restart = 1'b0;
        sh_shift   = 1'b0;

        len_ok      = (len != '0) && (len <= LEN_W'(MAX_LEN));
        final_frame = !cont_q && (frames_q == REP_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (start && !abort && len_ok) begin
                    state_d   = ST_SEND;
                    frames_d  = repeats;
                    cont_d    = (repeats == '0);
                    gap_len_d = gap;
                    sh_load   = 1'b1;
                    x_d       = sh_first_bit;
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!sh_last) begin
                    sh_shift  = 1'b1;
                    x_d       = sh_shift_bit;
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else if (final_frame) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (!cont_q) begin
                        frames_d = frames_q - REP_W'(1);
                    end
                    busy_d = 1'b1;
                    if (gap_len_q == '0) begin
                        sh_restart = 1'b1;
                        x_d        = sh_restart_bit;
                        x_valid_d  = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_len_q;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (gap_cnt_q == GAP_W'(1)) begin
                        state_d    = ST_SEND;
                        sh_restart = 1'b1;
                        x_d        = sh_restart_bit;
                        x_valid_d  = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frames_q  <= '0;
            cont_q    <= 1'b0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frames_q  <= frames_d;
            cont_q    <= cont_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: hand-computed frames, gaps, abort,
// illegal starts, back-to-back starts, reset mid-frame and the 255-frame case.
module tb_sequence_generator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [7:0]  repeats;
    logic [3:0]  gap;
    logic        abort;
    logic        x, x_valid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    sequence_generator dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .repeats (repeats),
        .gap     (gap),
        .abort   (abort),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {busy, x_valid, x, done}.
    task automatic chk_out(input string tag, input logic eb, input logic ev,
                           input logic ex, input logic ed);
        chk(tag, {28'd0, busy, x_valid, x, done}, {28'd0, eb, ev, ex, ed});
    endtask

    task automatic cfg(input logic [15:0] p, input logic [4:0] l,
                       input logic [7:0] r, input logic [3:0] g);
        pattern = p;
        len     = l;
        repeats = r;
        gap     = g;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  v38, x38;
        logic [31:0] e39;
        int          nvalid, nones, done_at, any_done;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg(16'h0, 5'd0, 8'd0, 4'd0);
        tick;
        chk_out("reset_state", 0, 0, 0, 0);

        // Single frame 101, start on the first edge after reset release.
        reset = 1'b0;
        cfg(16'b101, 5'd3, 8'd1, 4'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_out("f101_bit0", 1, 1, 1, 0);
        tick;
        chk_out("f101_bit1", 1, 1, 0, 0);
        tick;
        chk_out("f101_bit2", 1, 1, 1, 0);
        tick;
        chk_out("f101_done", 0, 0, 0, 1);
        tick;
        chk_out("f101_after", 0, 0, 0, 0);

        // len 2, three frames, gap 2; inputs scrambled after acceptance.
        cfg(16'b10, 5'd2, 8'd3, 4'd2);
        start = 1'b1;
        tick;
        start = 1'b0;
        cfg(16'hFFFF, 5'd5, 8'd1, 4'd0);
        v38 = 10'b1100110011;
        x38 = 10'b1000100010;
        for (int i = 0; i < 10; i++) begin
            chk_out("gap2_stream", 1, v38[9-i], x38[9-i], 0);
            tick;
        end
        chk_out("gap2_done", 0, 0, 0, 1);
        tick;

        // 16-bit, two frames, no gap; a start during busy must be ignored.
        cfg(16'hA5C3, 5'd16, 8'd2, 4'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        e39 = 32'hA5C3A5C3;
        for (int i = 0; i < 32; i++) begin
            chk_out("a5c3_stream", 1, 1, e39[31-i], 0);
            if (i == 5) begin
                start = 1'b1;
                cfg(16'h0001, 5'd1, 8'd1, 4'd0);
            end
            if (i == 6) start = 1'b0;
            tick;
        end
        chk_out("a5c3_done", 0, 0, 0, 1);

        // Start on the done cycle: new frame 110 follows immediately.
        cfg(16'b110, 5'd3, 8'd1, 4'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_out("b2b_bit0", 1, 1, 1, 0);
        tick;
        chk_out("b2b_bit1", 1, 1, 1, 0);
        tick;
        chk_out("b2b_bit2", 1, 1, 0, 0);
        tick;
        chk_out("b2b_done", 0, 0, 0, 1);
        tick;

        // Continuous 101 with a 1-cycle gap, then abort.
        cfg(16'b101, 5'd3, 8'd0, 4'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_out("cont_stream", 1, (i % 4) != 3, (i % 4) == 0 || (i % 4) == 2, 0);
            tick;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk_out("cont_abort", 0, 0, 0, 0);
        any_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (done || busy) any_done = 1;
        end
        chk("cont_quiet_after_abort", any_done, 0);

        // Illegal lengths are ignored.
        cfg(16'b101, 5'd0, 8'd1, 4'd0);
        start = 1'b1;
        tick;
        chk_out("len0_ignored", 0, 0, 0, 0);
        len = 5'd17;
        tick;
        chk_out("len17_ignored", 0, 0, 0, 0);
        start = 1'b0;

        // Abort in IDLE blocks a same-cycle start.
        len   = 5'd3;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk_out("idle_abort_blocks", 0, 0, 0, 0);
        tick;
        chk_out("idle_abort_stays", 0, 0, 0, 0);

        // Abort coinciding with the final bit suppresses done.
        cfg(16'b11, 5'd2, 8'd1, 4'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_out("abort_last_bit0", 1, 1, 1, 0);
        tick;
        chk_out("abort_last_bit1", 1, 1, 1, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk_out("abort_last_nodone", 0, 0, 0, 0);
        tick;

        // Reset during the third bit of a 5-bit frame.
        cfg(16'b10110, 5'd5, 8'd1, 4'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk_out("rst_pre_bit2", 1, 1, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst_async_clear", 0, 0, 0, 0);
        tick;
        reset = 1'b0;
        tick;
        chk_out("rst_release_idle", 0, 0, 0, 0);
        tick;
        chk_out("rst_no_done", 0, 0, 0, 0);

        // Maximum frame count: 255 one-bit frames back to back.
        cfg(16'h0001, 5'd1, 8'd255, 4'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        nvalid  = 0;
        nones   = 0;
        done_at = -1;
        for (int c = 0; c < 300; c++) begin
            if (x_valid) nvalid++;
            if (x_valid && x) nones++;
            if (done && done_at < 0) done_at = c;
            tick;
        end
        chk("max_rep_valid_count", nvalid, 255);
        chk("max_rep_ones_count", nones, 255);
        chk("max_rep_done_cycle", done_at, 255);
        chk_out("max_rep_idle", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
